aes_key_sched_seq: RTL

- Iterative AES key-schedule engine for AES-128, AES-192 and AES-256. Takes one cipher key and expands it to the full round-key set at one 32-bit word per clock, into an internal round-key store.
- Serves round keys on a registered read port, indexed by round.
- Optional decrypt view applies InvMixColumns to the middle round keys. These are the keys the equivalent inverse cipher needs.
- Sits between key input and the multi-mode aes_decrypt_top/encrypt datapaths; replaces per-core key expansion.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_sbox.sv | 34 +++
 rtl/aes_key_sched_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aes_pkg : shared AES constants, mode lookups and GF(2^8) helpers       |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package aes_pkg;

   localparam logic [1:0] c_mode_aes128  = 2'b00;
   localparam logic [1:0] c_mode_aes192  = 2'b01;
   localparam logic [1:0] c_mode_aes256  = 2'b10;
   localparam logic [1:0] c_mode_illegal = 2'b11;
   localparam logic [7:0] c_rcon_init    = 8'h01;

   function automatic logic [3:0] nk_of(input logic [1:0] mode);
      case (mode)
         c_mode_aes192: return 4'd6;
         c_mode_aes256: return 4'd8;
         default:       return 4'd4;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input logic [1:0] mode);
      case (mode)
         c_mode_aes192: return 4'd12;
         c_mode_aes256: return 4'd14;
         default:       return 4'd10;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Column byte 0 is the most significant byte of the word.
   function automatic logic [31:0] inv_mix_word(input logic [31:0] col);
      logic [7:0] a  [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int k = 0; k < 4; k++) begin
         a[k]  = col[31-8*k -: 8];
         x2    = xtime(a[k]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[k] = x8 ^ a[k];
         mb[k] = x8 ^ x2 ^ a[k];
         md[k] = x8 ^ x4 ^ a[k];
         me[k] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aes_sbox : combinational 8-bit forward AES S-box                      |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module aes_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   // Entry 0 occupies the top byte of the table.
   localparam logic [2047:0] c_sbox = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign o_byte = c_sbox[{~i_byte, 3'b000} +: 8];

endmodule
`default_nettype wire

// File: rtl/aes_key_sched_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aes_key_sched_seq : iterative AES-128/192/256 key expansion, one word  |
// | per clock, with a registered round-key read port and decrypt view.     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module aes_key_sched_seq
   import aes_pkg::*;
#(
   parameter int KEY_W     = 256,
   parameter int EQ_INV    = 1,
   parameter int MAX_WORDS = 60
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [KEY_W-1:0] key,
   output logic             busy,
   output logic             ready,
   output logic             err,
   output logic [3:0]       nr,
   input  logic             rd_en,
   input  logic [3:0]       rd_round,
   input  logic             rd_dec,
   output logic             rd_valid,
   output logic [127:0]     rd_key
);

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_expand = 2'd1;
   localparam logic [1:0] c_st_done   = 2'd2;

   logic [1:0]   r_state, w_state_nxt;
   logic         w_busy, w_ready;
   logic [31:0]  r_w [0:MAX_WORDS-1];
   logic [5:0]   r_i;
   logic [3:0]   r_j, r_nk, r_nr;
   logic [7:0]   r_rcon;
   logic         r_err, r_rd_valid;
   logic [127:0] r_rd_key;

   logic         w_start_ok, w_start_bad, w_last;
   logic [255:0] w_key_aligned;
   logic [31:0]  w_prev, w_sub_in, w_sub_out, w_t;
   logic [5:0]   w_rd_base;
   logic [127:0] w_rd_raw, w_rd_imc;
   logic         w_rd_ok, w_rd_inv;

   assign w_start_ok  = start && (r_state != c_st_expand) && (mode != c_mode_illegal);
   assign w_start_bad = start && (r_state != c_st_expand) && (mode == c_mode_illegal);
   assign w_last      = (r_i == ({r_nr, 2'b00} + 6'd3));

   // Left-justify the key so word k always sits at the same bit position.
   assign w_key_aligned = key << {4'd8 - nk_of(mode), 5'b00000};

   // ---------------- FSM: state register / next state / outputs ----------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= c_st_idle;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_expand: if (w_last) w_state_nxt = c_st_done;
         default: begin
            if (w_start_ok)       w_state_nxt = c_st_expand;
            else if (w_start_bad) w_state_nxt = c_st_idle;
         end
      endcase
   end

   always_comb begin
      w_busy  = (r_state == c_st_expand);
      w_ready = (r_state == c_st_done);
   end

   // ---------------- Expansion datapath ----------------------------------
   assign w_prev   = r_w[r_i - 6'd1];
   assign w_sub_in = (r_j == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .i_byte (w_sub_in[8*g +: 8]),
         .o_byte (w_sub_out[8*g +: 8])
      );
   end

   always_comb begin
      w_t = w_prev;
      if (r_j == 4'd0)                        w_t = w_sub_out ^ {r_rcon, 24'h0};
      else if (r_nk == 4'd8 && r_j == 4'd4)   w_t = w_sub_out;
   end

   always_ff @(posedge clk) begin
      if (w_start_ok) begin
         for (int k = 0; k < 8; k++)
            if (k < int'(nk_of(mode))) r_w[k] <= w_key_aligned[255-32*k -: 32];
      end else if (w_busy) begin
         r_w[r_i] <= r_w[r_i - {2'b00, r_nk}] ^ w_t;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err  <= 1'b0;
         r_nr   <= 4'd0;
         r_nk   <= 4'd4;
         r_i    <= 6'd0;
         r_j    <= 4'd0;
         r_rcon <= c_rcon_init;
      end else if (w_start_ok) begin
         r_err  <= 1'b0;
         r_nr   <= nr_of(mode);
         r_nk   <= nk_of(mode);
         r_i    <= {2'b00, nk_of(mode)};
         r_j    <= 4'd0;
         r_rcon <= c_rcon_init;
      end else if (w_start_bad) begin
         r_err  <= 1'b1;
      end else if (w_busy) begin
         r_i <= r_i + 6'd1;
         if (r_j == r_nk - 4'd1) begin
            r_j    <= 4'd0;
            r_rcon <= xtime(r_rcon);
         end else begin
            r_j <= r_j + 4'd1;
         end
      end
   end

   // ---------------- Read port -------------------------------------------
   assign w_rd_base = {rd_round, 2'b00};
   assign w_rd_raw  = {r_w[w_rd_base], r_w[w_rd_base + 6'd1],
                       r_w[w_rd_base + 6'd2], r_w[w_rd_base + 6'd3]};
   assign w_rd_imc  = {inv_mix_word(w_rd_raw[127:96]), inv_mix_word(w_rd_raw[95:64]),
                       inv_mix_word(w_rd_raw[63:32]),  inv_mix_word(w_rd_raw[31:0])};
   assign w_rd_ok   = rd_en && w_ready && (rd_round <= r_nr);
   assign w_rd_inv  = (EQ_INV != 0) && rd_dec && (rd_round != 4'd0) && (rd_round < r_nr);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_valid <= 1'b0;
         r_rd_key   <= '0;
      end else if (w_rd_ok) begin
         r_rd_valid <= 1'b1;
         r_rd_key   <= w_rd_inv ? w_rd_imc : w_rd_raw;
      end else begin
         r_rd_valid <= 1'b0;
         r_rd_key   <= '0;
      end
   end

   assign busy     = w_busy;
   assign ready    = w_ready;
   assign err      = r_err;
   assign nr       = r_nr;
   assign rd_valid = r_rd_valid;
   assign rd_key   = r_rd_key;

endmodule
`default_nettype wire
